// File: rtl/uart_pkg.sv
// Shared constants, state encodings and packet helpers for the status-packet UART transmitter.
package uart_pkg;

    localparam int         DEFAULT_CLKS_PER_BIT = 10417;
    localparam logic [7:0] HEADER               = 8'hA5;
    localparam int         PKT_LEN              = 5;

    typedef enum logic [1:0] {
        FRAME_IDLE,
        FRAME_SEND_BYTE,
        FRAME_NEXT,
        FRAME_DONE
    } frameState_e;

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bitState_e;

    // Packet layout: header, player HP, monster HP, game state, checksum.
    function automatic logic [7:0] packetByte(
        input logic [2:0] idx,
        input logic [7:0] playerHp,
        input logic [7:0] monHp,
        input logic [7:0] gameState,
        input logic [7:0] checksum
    );
        logic [7:0] value;
        case (idx)
            3'd0:    value = HEADER;
            3'd1:    value = playerHp;
            3'd2:    value = monHp;
            3'd3:    value = gameState;
            default: value = checksum;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 byte serializer, LSB first. A start request in the last stop-bit cycle
// chains straight into the next start bit so bytes go out with no idle gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_busy,
    output logic       byte_done
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    bitState_e         state, stateNext;
    logic [BAUD_W-1:0] baudCnt, baudCntNext;
    logic [2:0]        bitCnt, bitCntNext;
    logic [7:0]        shiftReg, shiftRegNext;
    logic              baudLast;

    assign baudLast = (baudCnt == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BIT_IDLE;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudCntNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftRegNext;
        end
    end

    always_comb begin
        stateNext    = state;
        baudCntNext  = baudLast ? '0 : baudCnt + 1'b1;
        bitCntNext   = bitCnt;
        shiftRegNext = shiftReg;
        case (state)
            BIT_IDLE: begin
                baudCntNext = '0;
                if (start) begin
                    stateNext    = BIT_START;
                    shiftRegNext = data;
                end
            end
            BIT_START: begin
                if (baudLast) begin
                    stateNext  = BIT_DATA;
                    bitCntNext = '0;
                end
            end
            BIT_DATA: begin
                if (baudLast) begin
                    shiftRegNext = {1'b0, shiftReg[7:1]};
                    bitCntNext   = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        stateNext = BIT_STOP;
                    end
                end
            end
            BIT_STOP: begin
                if (baudLast) begin
                    if (start) begin
                        stateNext    = BIT_START;
                        shiftRegNext = data;
                    end else begin
                        stateNext = BIT_IDLE;
                    end
                end
            end
            default: stateNext = BIT_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            BIT_START: tx = 1'b0;
            BIT_DATA:  tx = shiftReg[0];
            default:   tx = 1'b1;
        endcase
        byte_busy = (state != BIT_IDLE);
        byte_done = (state == BIT_STOP) && baudLast;
    end

endmodule

// File: rtl/uart_status_tx.sv
// Status packet transmitter: snapshots HP/state on a send request and streams
// header, three payload bytes and an XOR checksum as back-to-back 8N1 bytes.
module uart_status_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] player_hp,
    input  logic [7:0] mon_hp,
    input  logic [7:0] game_state,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    frameState_e frameState, frameStateNext;
    logic [2:0]  byteIdx, byteIdxNext;
    logic [7:0]  playerHpSnap, monHpSnap, gameStateSnap, checksumSnap;
    logic        accept, lastByte, byteStart, byteBusy, byteDone;
    logic [7:0]  byteData;

    assign accept    = send && !busy;
    assign lastByte  = (byteIdx == 3'(PKT_LEN - 1));
    assign byteStart = accept || ((frameState == FRAME_SEND_BYTE) && byteDone && !lastByte);
    // The header is a constant, so the first byte need not wait for the snapshot to land.
    assign byteData  = accept ? HEADER
                              : packetByte(byteIdx + 3'd1, playerHpSnap, monHpSnap,
                                           gameStateSnap, checksumSnap);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frameState <= FRAME_IDLE;
            byteIdx    <= '0;
        end else begin
            frameState <= frameStateNext;
            byteIdx    <= byteIdxNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            playerHpSnap  <= '0;
            monHpSnap     <= '0;
            gameStateSnap <= '0;
            checksumSnap  <= '0;
        end else if (accept) begin
            playerHpSnap  <= player_hp;
            monHpSnap     <= mon_hp;
            gameStateSnap <= game_state;
            checksumSnap  <= player_hp ^ mon_hp ^ game_state;
        end
    end

    // NEXT is resolved in the same cycle the stop bit ends, so it is never a resting state.
    always_comb begin
        frameStateNext = frameState;
        byteIdxNext    = byteIdx;
        case (frameState)
            FRAME_IDLE, FRAME_DONE: begin
                frameStateNext = FRAME_IDLE;
                if (accept) begin
                    frameStateNext = FRAME_SEND_BYTE;
                    byteIdxNext    = '0;
                end
            end
            FRAME_SEND_BYTE: begin
                if (byteDone) begin
                    if (!lastByte) begin
                        byteIdxNext = byteIdx + 3'd1;
                    end else begin
                        frameStateNext = FRAME_DONE;
                    end
                end
            end
            default: frameStateNext = FRAME_IDLE;
        endcase
    end

    always_comb begin
        busy = (frameState == FRAME_SEND_BYTE) && byteBusy;
        done = (frameState == FRAME_DONE);
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) byteTx (
        .clk       (clk),
        .reset     (reset),
        .start     (byteStart),
        .data      (byteData),
        .tx        (tx),
        .byte_busy (byteBusy),
        .byte_done (byteDone)
    );

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: line-level waveform model plus mid-bit receiver on a fast-baud
// instance, and a default-baud instance decoded by a 9600-baud reference receiver.
module tb_uart_status_tx;

    localparam int CPB      = 4;
    localparam int PKT_CYC  = 50 * CPB;
    localparam int CPB_FULL = 10417;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, send, tx, busy, done;
    logic [7:0] playerHp, monHp, gameState;
    logic       reset2, send2, tx2, busy2, done2;
    logic [7:0] playerHp2, monHp2, gameState2;

    int nCompared   = 0;
    int nMismatched = 0;
    bit defaultDone = 1'b0;

    uart_status_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .send(send), .player_hp(playerHp), .mon_hp(monHp),
        .game_state(gameState), .tx(tx), .busy(busy), .done(done)
    );

    uart_status_tx dut2 (
        .clk(clk), .reset(reset2), .send(send2), .player_hp(playerHp2), .mon_hp(monHp2),
        .game_state(gameState2), .tx(tx2), .busy(busy2), .done(done2)
    );

    // Request one packet from idle; returns on the first start-bit cycle.
    task automatic start_packet(input string name, input logic [7:0] p, input logic [7:0] m,
                                input logic [7:0] g);
        @(negedge clk);
        send = 1'b1; playerHp = p; monHp = m; gameState = g;
        @(negedge clk);
        send = 1'b0;
        nCompared++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            nMismatched++;
            $display("FAIL %s accept_latency: tx=%b busy=%b, required tx=0 busy=1", name, tx, busy);
        end
        $display("%s: requested %h %h %h", name, p, m, g);
    endtask

    // Called on the first start-bit cycle; checks the whole line against the expected
    // 50-bit waveform, decodes mid-bit, and ends on the DONE cycle.
    task automatic check_packet(input string name, input logic [7:0] p, input logic [7:0] m,
                                input logic [7:0] g, input bit disturb);
        logic [7:0] exp [5];
        logic [7:0] got [5];
        logic       line [$];
        int txErr = 0, busyErr = 0, doneErr = 0;
        exp[0] = 8'hA5; exp[1] = p; exp[2] = m; exp[3] = g; exp[4] = p ^ m ^ g;
        for (int b = 0; b < 5; b++) begin
            got[b] = 8'h00;
            line.push_back(1'b0);
            for (int k = 0; k < 8; k++) line.push_back(exp[b][k]);
            line.push_back(1'b1);
        end
        for (int i = 0; i < PKT_CYC; i++) begin
            int bitPos = i / CPB;
            if (tx !== line[bitPos]) txErr++;
            if (busy !== 1'b1) busyErr++;
            if (done !== 1'b0) doneErr++;
            if ((i % CPB) == CPB / 2 && (bitPos % 10) >= 1 && (bitPos % 10) <= 8)
                got[bitPos / 10][(bitPos % 10) - 1] = tx;
            if (disturb) begin
                send = 1'($urandom_range(0, 1));
                playerHp = 8'hFF; monHp = 8'hFF; gameState = 8'hFF;
            end
            @(negedge clk);
        end
        if (disturb) send = 1'b0;
        nCompared += 4;
        if (txErr != 0) begin
            nMismatched++;
            $display("FAIL %s tx_waveform: %0d cycles wrong, required 0", name, txErr);
        end
        if (busyErr != 0) begin
            nMismatched++;
            $display("FAIL %s busy_during: %0d cycles low, required 0", name, busyErr);
        end
        if (doneErr != 0) begin
            nMismatched++;
            $display("FAIL %s done_early: %0d cycles high, required 0", name, doneErr);
        end
        if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            nMismatched++;
            $display("FAIL %s done_cycle: done=%b busy=%b tx=%b, required 1 0 1", name, done, busy, tx);
        end
        for (int b = 0; b < 5; b++) begin
            nCompared++;
            if (got[b] !== exp[b]) begin
                nMismatched++;
                $display("FAIL %s byte%0d: got %h, required %h", name, b, got[b], exp[b]);
            end
        end
        $display("%s: decoded %h %h %h %h %h", name, got[0], got[1], got[2], got[3], got[4]);
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        nCompared++;
        if (bad != 0) begin
            nMismatched++;
            $display("FAIL %s quiet: %0d active cycles, required 0", name, bad);
        end
        $display("%s: idle for %0d cycles", name, cycles);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        nCompared++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_hold: tx=%b busy=%b done=%b, required 1 0 0", tx, busy, done);
        end
        reset = 1'b1;
        check_quiet("reset_release", 100);
    endtask

    task automatic test_fixed_packet();
        start_packet("fixed", 8'h64, 8'h32, 8'h90);
        check_packet("fixed", 8'h64, 8'h32, 8'h90, 1'b0);
        @(negedge clk);
        nCompared++;
        if (done !== 1'b0) begin
            nMismatched++;
            $display("FAIL fixed done_width: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_ignore_busy();
        start_packet("ignore_busy", 8'h64, 8'h32, 8'h90);
        check_packet("ignore_busy", 8'h64, 8'h32, 8'h90, 1'b1);
        check_quiet("ignore_busy_after", 30 * CPB);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            logic [7:0] p = 8'($urandom), m = 8'($urandom), g = 8'($urandom);
            start_packet("random", p, m, g);
            check_packet("random", p, m, g, 1'b0);
            check_quiet("random_after", 2);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        send = 1'b1; playerHp = 8'h01; monHp = 8'h02; gameState = 8'h03;
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            nCompared++;
            if (tx !== 1'b0 || busy !== 1'b1) begin
                nMismatched++;
                $display("FAIL back_to_back start%0d: tx=%b busy=%b, required 0 1", n, tx, busy);
            end
            check_packet("back_to_back", 8'h01, 8'h02, 8'h03, 1'b0);
            if (n == 2) send = 1'b0;
            else @(negedge clk);
        end
        check_quiet("back_to_back_end", 20);
    endtask

    task automatic test_reset_abort();
        logic [7:0] m = 8'($urandom) & 8'hF7;
        start_packet("reset_abort", 8'($urandom), m, 8'($urandom));
        repeat (2 * 10 * CPB + 4 * CPB + 1) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        nCompared++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_abort async: tx=%b busy=%b done=%b, required 1 0 0", tx, busy, done);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_quiet("reset_abort_after", 60 * CPB);
        begin
            logic [7:0] p = 8'($urandom), m2 = 8'($urandom), g = 8'($urandom);
            start_packet("reset_fresh", p, m2, g);
            check_packet("reset_fresh", p, m2, g, 1'b0);
        end
    endtask

    // Reference 9600-baud receiver sampling at mid-bit in real time (10 ns clock).
    task automatic test_default_baud();
        int         startLen = -1;
        logic [7:0] got = 8'h00;
        int         sampleAt [8];
        for (int k = 0; k < 8; k++) sampleAt[k] = int'((real'(k) + 1.5) * 10416.6667);
        reset2 = 1'b0;
        repeat (3) @(negedge clk);
        reset2 = 1'b1;
        @(negedge clk);
        send2 = 1'b1; playerHp2 = 8'h11; monHp2 = 8'h22; gameState2 = 8'h33;
        @(negedge clk);
        send2 = 1'b0;
        nCompared++;
        if (tx2 !== 1'b0 || busy2 !== 1'b1 || done2 !== 1'b0) begin
            nMismatched++;
            $display("FAIL default_baud start: tx=%b busy=%b done=%b, required 0 1 0", tx2, busy2, done2);
        end
        for (int i = 0; i <= sampleAt[7]; i++) begin
            if (startLen < 0 && tx2 === 1'b1) startLen = i;
            for (int k = 0; k < 8; k++) if (i == sampleAt[k]) got[k] = tx2;
            @(negedge clk);
        end
        nCompared += 2;
        if (startLen != CPB_FULL) begin
            nMismatched++;
            $display("FAIL default_baud start_len: %0d cycles, required %0d", startLen, CPB_FULL);
        end
        if (got !== 8'hA5) begin
            nMismatched++;
            $display("FAIL default_baud header: got %h, required a5", got);
        end
        $display("default_baud: start bit %0d cycles, header %h", startLen, got);
        defaultDone = 1'b1;
    endtask

    initial begin
        reset = 1'b0; send = 1'b0; playerHp = 8'h00; monHp = 8'h00; gameState = 8'h00;
        reset2 = 1'b0; send2 = 1'b0; playerHp2 = 8'h00; monHp2 = 8'h00; gameState2 = 8'h00;
        fork
            test_default_baud();
        join_none
        test_reset();
        test_fixed_packet();
        test_ignore_busy();
        test_random();
        test_back_to_back();
        test_reset_abort();
        for (int i = 0; i < 100000 && !defaultDone; i++) @(negedge clk);
        if (!defaultDone) begin
            nCompared++;
            nMismatched++;
            $display("FAIL default_baud timeout: finished=0, required 1");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
